// File: rtl/serial_pattern_feeder_if.sv
// Signal bundle between a pattern source/controller and serial_pattern_feeder.
// The controller side drives start/abort/loop/pattern; the feeder drives the serial outputs.
interface serial_pattern_feeder_if;
  logic        start;
  logic        abort;
  logic        loop;
  logic [15:0] sw_pattern;
  logic [3:0]  sw_len;
  logic        ip_bit;
  logic        bit_valid;
  logic [3:0]  bit_idx;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, loop, sw_pattern, sw_len,
    input  ip_bit, bit_valid, bit_idx, busy, done
  );

  modport slave (
    input  start, abort, loop, sw_pattern, sw_len,
    output ip_bit, bit_valid, bit_idx, busy, done
  );
endinterface

// File: rtl/serial_pattern_feeder.sv
// Shifts a switch-selected 1..16 bit pattern out MSB first, one bit per TICK_DIV clocks,
// optionally looping, for driving a downstream sequence detector.
module serial_pattern_feeder #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_pattern_feeder_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LAST
  } state_t;

  state_t        state, state_d;
  logic          start_q;
  logic          start_edge;
  logic          loop_q, loop_d;
  logic [15:0]   shadow, shadow_d;
  logic [15:0]   sh, sh_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    cnt, cnt_d;
  logic [PW-1:0] presc, presc_d;
  logic          tick;
  logic          ip_bit_r, ip_bit_d;
  logic          bit_valid_r, bit_valid_d;
  logic          done_r, done_d;
  logic [3:0]    bit_idx_r, bit_idx_d;

  assign start_edge = bus.start & ~start_q;
  assign tick       = (presc == PW'(TICK_DIV - 1));

  assign bus.ip_bit    = ip_bit_r;
  assign bus.bit_valid = bit_valid_r;
  assign bus.bit_idx   = bit_idx_r;
  assign bus.done      = done_r;
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      loop_q      <= 1'b0;
      shadow      <= '0;
      sh          <= '0;
      len_q       <= '0;
      cnt         <= '0;
      presc       <= '0;
      ip_bit_r    <= 1'b1;
      bit_valid_r <= 1'b0;
      done_r      <= 1'b0;
      bit_idx_r   <= '0;
    end else begin
      state       <= state_d;
      start_q     <= bus.start;
      loop_q      <= loop_d;
      shadow      <= shadow_d;
      sh          <= sh_d;
      len_q       <= len_d;
      cnt         <= cnt_d;
      presc       <= presc_d;
      ip_bit_r    <= ip_bit_d;
      bit_valid_r <= bit_valid_d;
      done_r      <= done_d;
      bit_idx_r   <= bit_idx_d;
    end
  end

  always_comb begin
    state_d     = state;
    loop_d      = loop_q;
    shadow_d    = shadow;
    sh_d        = sh;
    len_d       = len_q;
    cnt_d       = cnt;
    presc_d     = '0;
    ip_bit_d    = ip_bit_r;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
    bit_idx_d   = bit_idx_r;

    unique case (state)
      IDLE: begin
        if (start_edge && !bus.abort) begin
          shadow_d = bus.sw_pattern;
          sh_d     = bus.sw_pattern;
          len_d    = bus.sw_len;
          cnt_d    = bus.sw_len;
          loop_d   = bus.loop;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.abort) begin
          state_d   = IDLE;
          ip_bit_d  = 1'b1;
          bit_idx_d = '0;
        end else begin
          presc_d = tick ? '0 : presc + PW'(1);
          if (tick) begin
            ip_bit_d    = sh[15];
            sh_d        = {sh[14:0], 1'b0};
            bit_valid_d = 1'b1;
            bit_idx_d   = len_q - cnt;
            if (cnt == '0) begin
              // Looping reloads in the same cycle as the final bit so the stream has no gap.
              if (loop_q) begin
                sh_d  = shadow;
                cnt_d = len_q;
              end else begin
                state_d = LAST;
              end
            end else begin
              cnt_d = cnt - 4'd1;
            end
          end
        end
      end

      LAST: begin
        if (bus.abort) begin
          state_d   = IDLE;
          ip_bit_d  = 1'b1;
          bit_idx_d = '0;
        end else begin
          presc_d = tick ? '0 : presc + PW'(1);
          if (tick) begin
            state_d   = IDLE;
            ip_bit_d  = 1'b1;
            bit_idx_d = '0;
            done_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        ip_bit_d  = 1'b1;
        bit_idx_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Directed bench for serial_pattern_feeder at TICK_DIV=4 with hand-derived bit timing.
module tb_serial_pattern_feeder;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_pattern_feeder_if bus ();

  serial_pattern_feeder #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until bit_valid (sel=0) or done (sel=1) is seen, within budget cycles.
  task automatic wait_flag(input bit sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((sel ? bus.done : bus.bit_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.loop = 1'b0;
    bus.sw_pattern = '0; bus.sw_len = '0;
    step(); step();
    n_cmp++; if (bus.ip_bit !== 1'b1) begin n_bad++; $display("FAIL reset_ip_bit: got %b want 1", bus.ip_bit); end
    n_cmp++; if (bus.bit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_bit_valid: got %b want 0", bus.bit_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.bit_idx !== 4'd0) begin n_bad++; $display("FAIL reset_bit_idx: got %0d want 0", bus.bit_idx); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_run();
    logic [7:0] exp_bits;
    int n;
    exp_bits = 8'b0000_0101;
    bus.sw_pattern = 16'h0500; bus.sw_len = 4'd7; bus.loop = 1'b0;
    bus.start = 1'b1;
    step();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_after_load: got %b want 1", bus.busy); end
    for (int k = 1; k <= 36; k++) begin
      logic exp_v;
      step();
      exp_v = ((k % 4) == 0) && (k <= 32);
      n_cmp++; if (bus.bit_valid !== exp_v) begin n_bad++; $display("FAIL single_valid_k%0d: got %b want %b", k, bus.bit_valid, exp_v); end
      n_cmp++; if (bus.done !== (k == 36)) begin n_bad++; $display("FAIL single_done_k%0d: got %b want %b", k, bus.done, (k == 36)); end
      if (exp_v) begin
        n = k / 4;
        n_cmp++; if (bus.ip_bit !== exp_bits[8-n]) begin n_bad++; $display("FAIL single_bit%0d: got %b want %b", n, bus.ip_bit, exp_bits[8-n]); end
        n_cmp++; if (bus.bit_idx !== 4'(n - 1)) begin n_bad++; $display("FAIL single_idx%0d: got %0d want %0d", n, bus.bit_idx, n - 1); end
      end
      if (k == 36) begin
        n_cmp++; if (bus.ip_bit !== 1'b1) begin n_bad++; $display("FAIL single_idle_ip_bit: got %b want 1", bus.ip_bit); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
      end
    end
    bus.start = 1'b0;
    step();
  endtask

  task automatic test_loop_abort();
    bus.sw_pattern = 16'h8000; bus.sw_len = 4'd1; bus.loop = 1'b1;
    bus.start = 1'b1;
    step();
    for (int k = 1; k <= 24; k++) begin
      logic exp_v;
      step();
      exp_v = ((k % 4) == 0);
      n_cmp++; if (bus.bit_valid !== exp_v) begin n_bad++; $display("FAIL loop_valid_k%0d: got %b want %b", k, bus.bit_valid, exp_v); end
      n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL loop_done_k%0d: got %b want 0", k, bus.done); end
      if (exp_v) begin
        n_cmp++; if (bus.ip_bit !== 1'((k / 4) % 2)) begin n_bad++; $display("FAIL loop_bit_k%0d: got %b want %b", k, bus.ip_bit, 1'((k / 4) % 2)); end
      end
    end
    bus.abort = 1'b1;
    step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.ip_bit !== 1'b1) begin n_bad++; $display("FAIL abort_ip_bit: got %b want 1", bus.ip_bit); end
    n_cmp++; if (bus.bit_idx !== 4'd0) begin n_bad++; $display("FAIL abort_bit_idx: got %0d want 0", bus.bit_idx); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", bus.done); end
    bus.abort = 1'b0; bus.start = 1'b0; bus.loop = 1'b0;
    step();
  endtask

  task automatic test_abort_in_idle();
    bus.sw_pattern = 16'hFFFF; bus.sw_len = 4'd3;
    bus.abort = 1'b1; bus.start = 1'b1;
    step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_abort_start_busy: got %b want 0", bus.busy); end
    bus.abort = 1'b0;
    step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_held_start_busy: got %b want 0", bus.busy); end
    bus.start = 1'b0;
    step();
  endtask

  task automatic test_held_start();
    int nv, nd, nboth;
    nv = 0; nd = 0; nboth = 0;
    bus.sw_pattern = 16'hB000; bus.sw_len = 4'd3; bus.loop = 1'b0;
    bus.start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.bit_valid === 1'b1) nv++;
      if (bus.done === 1'b1) nd++;
      if (bus.bit_valid === 1'b1 && bus.done === 1'b1) nboth++;
    end
    n_cmp++; if (nv !== 4) begin n_bad++; $display("FAIL held_valid_count: got %0d want 4", nv); end
    n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL held_done_count: got %0d want 1", nd); end
    n_cmp++; if (nboth !== 0) begin n_bad++; $display("FAIL held_valid_done_overlap: got %0d want 0", nboth); end
    bus.start = 1'b0;
    step();
  endtask

  task automatic test_pattern_change();
    bit ok;
    bus.sw_pattern = 16'hF000; bus.sw_len = 4'd3; bus.loop = 1'b0;
    bus.start = 1'b1;
    step();
    wait_flag(1'b0, 8, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL chg_first_valid_timeout: got none want 1"); end
    n_cmp++; if (bus.ip_bit !== 1'b1) begin n_bad++; $display("FAIL chg_bit0: got %b want 1", bus.ip_bit); end
    bus.sw_pattern = 16'h0000; bus.sw_len = 4'd0; bus.loop = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_flag(1'b0, 8, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL chg_valid%0d_timeout: got none want 1", i); end
      n_cmp++; if (bus.ip_bit !== 1'b1) begin n_bad++; $display("FAIL chg_bit%0d: got %b want 1", i, bus.ip_bit); end
      n_cmp++; if (bus.bit_idx !== 4'(i)) begin n_bad++; $display("FAIL chg_idx%0d: got %0d want %0d", i, bus.bit_idx, i); end
    end
    wait_flag(1'b1, 8, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL chg_done_timeout: got none want done"); end
    bus.start = 1'b0; bus.loop = 1'b0;
    step();
  endtask

  task automatic test_reset_midrun();
    bit ok;
    bus.sw_pattern = 16'hA5C3; bus.sw_len = 4'd15; bus.loop = 1'b0;
    bus.start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      wait_flag(1'b0, 8, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_valid%0d_timeout: got none want 1", i); end
    end
    rst = 1'b1;
    step();
    n_cmp++; if (bus.ip_bit !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ip_bit: got %b want 1", bus.ip_bit); end
    n_cmp++; if (bus.bit_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_bit_valid: got %b want 0", bus.bit_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.bit_idx !== 4'd0) begin n_bad++; $display("FAIL mid_rst_bit_idx: got %0d want 0", bus.bit_idx); end
    rst = 1'b0; bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++; if (bus.bit_valid !== (k == 4)) begin n_bad++; $display("FAIL restart_valid_k%0d: got %b want %b", k, bus.bit_valid, (k == 4)); end
    end
    n_cmp++; if (bus.bit_idx !== 4'd0) begin n_bad++; $display("FAIL restart_idx: got %0d want 0", bus.bit_idx); end
    n_cmp++; if (bus.ip_bit !== 1'b1) begin n_bad++; $display("FAIL restart_bit: got %b want 1", bus.ip_bit); end
    bus.start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_loop_abort();
    test_abort_in_idle();
    test_held_start();
    test_pattern_change();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
